// File: rtl/asrv32_prefetch_pkg.sv
// Shared types for the ASRV32 instruction prefetch unit.
//   pf_state_e : fetch engine states (normal fetch / drop stale outstanding request)
//   pf_entry_t : one queue entry, the fetched word tagged with its PC
package asrv32_prefetch_pkg;

  typedef enum logic [0:0] {
    PfFetch = 1'b0,
    PfDrop  = 1'b1
  } pf_state_e;

  localparam int unsigned PfEntryW = 64;
  localparam logic [31:0] PfAddrStep = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pf_entry_t;

endpackage

// File: rtl/asrv32_prefetch_if.sv
// Bus bundle of the prefetch unit: instruction-memory req/ack side and the
// valid/ready/flush side towards the core.
//   master : the prefetch unit
//   slave  : memory + core (or a testbench standing in for them)
interface asrv32_prefetch_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             o_imem_req;
  logic [31:0]      o_imem_addr;
  logic             i_imem_ack;
  logic [31:0]      i_imem_rdata;
  logic             o_inst_valid;
  logic [31:0]      o_inst;
  logic [31:0]      o_inst_pc;
  logic             i_inst_ready;
  logic             i_flush;
  logic [31:0]      i_flush_pc;
  logic [CNT_W-1:0] o_count;

  modport master (
    output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_count,
    input  i_imem_ack, i_imem_rdata, i_inst_ready, i_flush, i_flush_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_count,
    output i_imem_ack, i_imem_rdata, i_inst_ready, i_flush, i_flush_pc
  );

endinterface

// File: rtl/asrv32_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : empty the FIFO (wins over push/pop)
//   push_i/wdata_i: write, ignored when full
//   pop_i         : drop head, ignored when empty
//   rdata_o       : head entry straight from storage
//   empty_o/full_o/count_o : occupancy status
module asrv32_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrOne;
      if (do_pop)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: nothing is read out unless the pointers say valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/asrv32_prefetch.sv
// ASRV32 instruction prefetch unit. Fetches words over a req/ack bus into a
// PC-tagged FWFT queue that the core drains with valid/ready; a flush discards
// the queue and redirects fetching. An outstanding request cannot be aborted,
// so a flush during a wait parks in PfDrop until the stale ack arrives.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (master)   : imem req/addr/ack/rdata, inst valid/inst/pc/ready,
//                    flush/flush_pc, queue occupancy count
module asrv32_prefetch
  import asrv32_prefetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  asrv32_prefetch_if.master  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  pf_state_e        state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      redir_q, redir_d;

  logic             ack_ok, push, pop, clr;
  logic             fifo_empty, fifo_full, head_valid;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      flush_tgt;
  pf_entry_t        head, wentry;

  assign ack_ok     = bus.i_imem_ack & req_q;
  assign head_valid = ~fifo_empty;
  assign flush_tgt  = {bus.i_flush_pc[31:2], 2'b00};
  assign wentry     = '{pc: addr_q, inst: bus.i_imem_rdata};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    redir_d = redir_q;
    clr     = 1'b0;
    push    = 1'b0;
    // Flush beats a same-cycle pop.
    pop     = head_valid & bus.i_inst_ready & ~bus.i_flush;
    unique case (state_q)
      PfFetch: begin
        if (bus.i_flush) begin
          clr = 1'b1;
          if (!req_q || ack_ok) begin
            addr_d = flush_tgt;
          end else begin
            redir_d = flush_tgt;
            state_d = PfDrop;
          end
        end else if (ack_ok) begin
          push   = 1'b1;
          addr_d = addr_q + PfAddrStep;
        end
      end
      PfDrop: begin
        if (bus.i_flush) begin
          clr     = 1'b1;
          redir_d = flush_tgt;
        end
        // A flush coinciding with the stale ack takes the newer target.
        if (ack_ok) begin
          addr_d  = bus.i_flush ? flush_tgt : redir_q;
          state_d = PfFetch;
        end
      end
      default: state_d = PfFetch;
    endcase
    count_nxt = clr ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    // Only request when the next-cycle queue has room, so an ack never lands when full.
    req_d = (count_nxt < CNT_W'(DEPTH)) || (state_d == PfDrop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PfFetch;
      req_q   <= 1'b0;
      addr_q  <= PC_RESET;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      redir_q <= redir_d;
    end
  end

  asrv32_sync_fifo #(
    .WIDTH (PfEntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count)
  );

  assign bus.o_imem_req   = req_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_inst_valid = head_valid;
  assign bus.o_inst       = head_valid ? head.inst : 32'h0;
  assign bus.o_inst_pc    = head_valid ? head.pc : 32'h0;
  assign bus.o_count      = count;

  // An ack without a request is a bus protocol error; the RTL ignores it.
  a_ack_needs_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.i_imem_ack |-> req_q);
  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    push |-> !fifo_full);

endmodule
